// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared types for the icache refill engine and the core's
// icache write mux.
package icache_refill_pkg;

    // Refill engine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } icache_refill_state_e;

    // Widest index/tag field carried by the shared write-request struct.
    localparam int unsigned icache_wr_field_width_gp = 64;

    // One icache write request; narrower index/tag values are zero-extended.
    typedef struct packed {
        logic                                v;
        logic [icache_wr_field_width_gp-1:0] addr;
        logic [icache_wr_field_width_gp-1:0] tag;
        logic [31:0]                         instr;
    } icache_wr_req_s;

    // Word offset inside a line: (first + cnt) modulo 2**lg_words.
    function automatic logic [63:0] line_offset(input logic [63:0]  first,
                                                input logic [63:0]  cnt,
                                                input int unsigned  lg_words);
        return (first + cnt) & ((64'd1 << lg_words) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_refill_out_counter.sv
// icache_refill_out_counter: up/down counter of outstanding memory requests,
// held at its bounds and checked against overflow/underflow in simulation.
module icache_refill_out_counter
    import icache_refill_pkg::*;
#(
    parameter int unsigned max_val_p = 4,
    parameter int unsigned width_p   = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [width_p-1:0] count_o,
    output logic [width_p-1:0] count_next_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_q, count_d;

    // Next count: simultaneous inc and dec cancel; bounds are never crossed.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != max_lp)) begin
            count_d = count_q + width_p'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - width_p'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

    no_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(inc_i && !dec_i && (count_q == max_lp)));

    no_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/icache_refill.sv
// icache_refill: on an icache miss, fetch the aligned line from memory one
// word per handshake and write each returned word straight into the icache.
// Optional build macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN: start the line at
// the missing word and wrap within the line.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int icache_tag_width_p  = -1,
    parameter int icache_addr_width_p = -1,
    parameter int line_words_p        = 4,
    parameter int max_out_p           = 4,
    localparam int pc_width_lp = icache_tag_width_p + icache_addr_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           miss_v_i,
    input  logic [pc_width_lp-1:0]         miss_pc_i,
    input  logic                           flush_i,
    output logic                           busy_o,
    output logic                           refill_done_o,
    output logic                           mem_req_v_o,
    output logic [pc_width_lp-1:0]         mem_req_addr_o,
    input  logic                           mem_req_ready_i,
    input  logic                           mem_resp_v_i,
    input  logic [31:0]                    mem_resp_data_i,
    output logic                           icache_w_v_o,
    output logic [icache_addr_width_p-1:0] icache_w_addr_o,
    output logic [icache_tag_width_p-1:0]  icache_w_tag_o,
    output logic [31:0]                    icache_w_instr_o
);

    localparam int lg_line_lp = $clog2(line_words_p);
    localparam int lg_out_lp  = $clog2(max_out_p);
    localparam int cnt_w_lp   = lg_line_lp + 1;
    localparam int out_w_lp   = lg_out_lp + 1;
    localparam int line_w_lp  = pc_width_lp - lg_line_lp;

    localparam logic [cnt_w_lp-1:0] line_cnt_lp = cnt_w_lp'(line_words_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(line_words_p - 1);
    localparam logic [out_w_lp-1:0] max_out_lp  = out_w_lp'(max_out_p);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit cwf_en_lp = 1'b1;
`else
    localparam bit cwf_en_lp = 1'b0;
`endif

    logic [1:0]            state_q, state_d;
    logic [line_w_lp-1:0]  line_q, line_d;
    logic [lg_line_lp-1:0] first_q, first_d;
    logic [cnt_w_lp-1:0]   req_cnt_q, req_cnt_d;
    logic [cnt_w_lp-1:0]   resp_cnt_q, resp_cnt_d;
    logic [out_w_lp-1:0]   out_cnt, out_cnt_d;

    logic                  fetch, drain;
    logic                  req_v, req_fire, resp_take, wr_v;
    logic [lg_line_lp-1:0] req_off, resp_off;
    logic [lg_line_lp-1:0] start_off;
    logic [pc_width_lp-1:0] resp_word_addr;

    assign fetch = (state_q == S_FETCH);
    assign drain = (state_q == S_DRAIN);

    // Without the critical-word-first build the start offset is always 0.
    assign start_off = cwf_en_lp ? first_q : '0;
    assign req_off   = lg_line_lp'(line_offset(64'(start_off), 64'(req_cnt_q), lg_line_lp));
    assign resp_off  = lg_line_lp'(line_offset(64'(start_off), 64'(resp_cnt_q), lg_line_lp));

    assign req_v     = fetch & ~flush_i & (req_cnt_q < line_cnt_lp) & (out_cnt < max_out_lp);
    assign req_fire  = req_v & mem_req_ready_i;
    assign resp_take = mem_resp_v_i & (fetch | drain);
    assign wr_v      = fetch & ~flush_i & mem_resp_v_i;

    assign resp_word_addr = {line_q, resp_off};

    icache_refill_out_counter #(
        .max_val_p (max_out_p),
        .width_p   (out_w_lp)
    ) u_out_cnt (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .inc_i        (req_fire),
        .dec_i        (resp_take),
        .count_o      (out_cnt),
        .count_next_o (out_cnt_d)
    );

    // Next-state and counter updates for the refill sequence.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        first_d    = first_q;
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (miss_v_i && !flush_i) begin
                    state_d    = S_FETCH;
                    line_d     = miss_pc_i[pc_width_lp-1:lg_line_lp];
                    first_d    = miss_pc_i[lg_line_lp-1:0];
                    req_cnt_d  = '0;
                    resp_cnt_d = '0;
                end
            end
            S_FETCH: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + cnt_w_lp'(1);
                end
                if (flush_i) begin
                    state_d = (out_cnt_d != '0) ? S_DRAIN : S_IDLE;
                end else if (wr_v) begin
                    resp_cnt_d = resp_cnt_q + cnt_w_lp'(1);
                    if (resp_cnt_q == last_cnt_lp) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            first_q    <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            first_q    <= first_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign refill_done_o    = (state_q == S_DONE);
    assign mem_req_v_o      = req_v;
    assign mem_req_addr_o   = {line_q, req_off};
    assign icache_w_v_o     = wr_v;
    assign icache_w_addr_o  = resp_word_addr[icache_addr_width_p-1:0];
    assign icache_w_tag_o   = resp_word_addr[pc_width_lp-1:icache_addr_width_p];
    assign icache_w_instr_o = wr_v ? mem_resp_data_i : '0;

    resp_in_idle_or_done_a: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> ((state_q == S_FETCH) || (state_q == S_DRAIN)));

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed table plus randomized refills against a
// line-level reference model of the refill engine.
module tb_icache_refill;

    localparam int TAG_W  = 8;
    localparam int ADDR_W = 8;
    localparam int LINE   = 4;
    localparam int MAXO   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_v;
    logic [15:0] miss_pc;
    logic        flush;
    logic        busy, done;
    logic        req_v;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        resp_v;
    logic [31:0] resp_data;
    logic        w_v;
    logic [7:0]  w_addr;
    logic [7:0]  w_tag;
    logic [31:0] w_instr;

    always #5 clk = ~clk;

    icache_refill #(
        .icache_tag_width_p  (TAG_W),
        .icache_addr_width_p (ADDR_W),
        .line_words_p        (LINE),
        .max_out_p           (MAXO)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .miss_v_i         (miss_v),
        .miss_pc_i        (miss_pc),
        .flush_i          (flush),
        .busy_o           (busy),
        .refill_done_o    (done),
        .mem_req_v_o      (req_v),
        .mem_req_addr_o   (req_addr),
        .mem_req_ready_i  (req_ready),
        .mem_resp_v_i     (resp_v),
        .mem_resp_data_i  (resp_data),
        .icache_w_v_o     (w_v),
        .icache_w_addr_o  (w_addr),
        .icache_w_tag_o   (w_tag),
        .icache_w_instr_o (w_instr)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // k-th word address of the refill line for a miss at pc.
    function automatic logic [15:0] exp_addr(input logic [15:0] pc, input int unsigned k);
        int unsigned p, base, off;
        p    = pc;
        base = (p / LINE) * LINE;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        off = ((p % LINE) + k) % LINE;
`else
        off = k % LINE;
`endif
        return 16'(base + off);
    endfunction

    function automatic logic [31:0] data_of(input logic [15:0] a, input logic [31:0] salt);
        return {a ^ 16'h5A5A, a} ^ salt;
    endfunction

    typedef struct {
        logic [15:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       memq[$];
    int unsigned cyc;

    // One refill from miss to idle; returns what the DUT did plus model flush info.
    task automatic run_refill(input logic [15:0] pc, input int unsigned lat,
                              input int unsigned ready_low, input int unsigned ready_pct,
                              input int flush_reqs, input int flush_writes,
                              output int dut_w, output int dut_d, output int dut_r,
                              output bit m_flushed, output int m_wflush);
        int          phase, outst, reqs, writes, fcyc;
        bit          fl, rdy, rv, acc, exp_rv, exp_wv;
        logic [31:0] salt, rdata;
        logic [15:0] ea;
        salt = $urandom;
        memq.delete();
        dut_w = 0; dut_d = 0; dut_r = 0; m_flushed = 0; m_wflush = 0;
        outst = 0; reqs = 0; writes = 0; fcyc = 0; cyc = 0;

        @(negedge clk);
        miss_v = 1'b1; miss_pc = pc; flush = 1'b0; req_ready = 1'b0; resp_v = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_req_v", req_v, 0);
        check("idle_w_v", w_v, 0);
        check("idle_done", done, 0);
        phase = 1;

        while (phase != 0) begin
            @(negedge clk);
            rdy = (fcyc >= ready_low) && ($urandom_range(0, 99) < ready_pct);
            fl = 1'b0;
            if (phase == 2 && m_flushed) fl = 1'b1;
            else if (flush_reqs >= 0 && !m_flushed && (phase == 1 || phase == 3) &&
                     reqs >= flush_reqs && writes >= flush_writes) fl = 1'b1;
            rv    = (memq.size() > 0) && (memq[0].due <= cyc);
            rdata = rv ? data_of(memq[0].addr, salt) : $urandom;
            miss_v = 1'($urandom_range(0, 1));
            flush = fl; req_ready = rdy; resp_v = rv; resp_data = rdata;
            #1;
            check("busy", busy, 1);
            check("done", done, (phase == 3) ? 1 : 0);
            exp_rv = (phase == 1) && !fl && (reqs < LINE) && (outst < MAXO);
            check("req_v", req_v, exp_rv);
            if (exp_rv) check("req_addr", req_addr, exp_addr(pc, reqs));
            exp_wv = (phase == 1) && rv && !fl;
            check("w_v", w_v, exp_wv);
            if (exp_wv) begin
                ea = exp_addr(pc, writes);
                check("w_addr", w_addr, ea % 256);
                check("w_tag", w_tag, ea / 256);
                check("w_instr", w_instr, rdata);
            end
            if (w_v) dut_w++;
            if (done) dut_d++;
            if (req_v && rdy) dut_r++;

            acc = exp_rv && rdy;
            if (rv) void'(memq.pop_front());
            if (acc) memq.push_back('{exp_addr(pc, reqs), cyc + lat});
            outst = outst + int'(acc) - int'(rv);
            reqs  = reqs + int'(acc);
            if (exp_wv) writes++;
            case (phase)
                1: begin
                    if (fl) begin
                        m_flushed = 1'b1; m_wflush = writes;
                        phase = (outst != 0) ? 2 : 0;
                    end else if (exp_wv && writes == LINE) begin
                        phase = 3;
                    end
                end
                2: if (outst == 0) phase = 0;
                default: begin
                    if (fl) begin m_flushed = 1'b1; m_wflush = writes; end
                    phase = 0;
                end
            endcase
            cyc++; fcyc++;
            if (fcyc > 400 && phase != 0) begin
                n_checks++;
                $display("FAIL cycle_budget: refill busy after %0d cycles, required idle", fcyc);
                rst = 1'b1; #1; rst = 1'b0;
                memq.delete();
                phase = 0;
            end
        end
    endtask

    typedef struct {
        logic [15:0] pc;
        int unsigned lat;
        int unsigned rlow;
        int          fr;
        int          fw;
        int          exp_w;
        int          exp_d;
        int          exp_r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  dw, dd, dr, wf;
        bit  fd;

        vecs[0] = '{16'h1236, 1, 0, -1, -1, 4, 1, 4};  // basic refill, 1-cycle memory
        vecs[1] = '{16'h1236, 1, 3, -1, -1, 4, 1, 4};  // ready low 3 cycles
        vecs[2] = '{16'h0000, 5, 0, -1, -1, 4, 1, 4};  // slow responses, outstanding cap
        vecs[3] = '{16'hFFFF, 3, 0, -1, -1, 4, 1, 4};  // top of address space
        vecs[4] = '{16'h2468, 4, 0,  2,  0, 0, 0, 2};  // flush with 2 outstanding -> drain
        vecs[5] = '{16'h1357, 2, 0,  2,  1, 1, 0, 2};  // flush discards same-cycle response
        vecs[6] = '{16'h0ABC, 1, 0,  4,  4, 4, 1, 4};  // flush during done still pulses
        vecs[7] = '{16'h7770, 1, 0,  0,  0, 0, 0, 0};  // flush on first fetch cycle

        rst = 1'b1; miss_v = 1'b0; miss_pc = '0; flush = 1'b0;
        req_ready = 1'b0; resp_v = 1'b0; resp_data = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_req_v", req_v, 0);
        check("rst_done", done, 0);
        check("rst_w_v", w_v, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_refill(vecs[i].pc, vecs[i].lat, vecs[i].rlow, 100, vecs[i].fr, vecs[i].fw,
                       dw, dd, dr, fd, wf);
            check($sformatf("vec%0d_writes", i), dw, vecs[i].exp_w);
            check($sformatf("vec%0d_done", i), dd, vecs[i].exp_d);
            check($sformatf("vec%0d_reqs", i), dr, vecs[i].exp_r);
        end

        // Asynchronous reset in the middle of a refill.
        @(negedge clk);
        miss_v = 1'b1; miss_pc = 16'h4445; flush = 1'b0; req_ready = 1'b1; resp_v = 1'b0;
        @(negedge clk);
        miss_v = 1'b0;
        #1 check("midfetch_busy", busy, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_req_v", req_v, 0);
        check("arst_req_addr", req_addr, 0);
        check("arst_w_v", w_v, 0);
        check("arst_w_addr", w_addr, 0);
        check("arst_w_tag", w_tag, 0);
        check("arst_w_instr", w_instr, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_refill(16'h4445, 1, 0, 100, -1, -1, dw, dd, dr, fd, wf);
        check("post_rst_writes", dw, 4);
        check("post_rst_done", dd, 1);
        check("post_rst_reqs", dr, 4);

        // Randomized refills.
        for (int i = 0; i < 24; i++) begin
            int fr, fw;
            fr = -1; fw = -1;
            if ($urandom_range(0, 1) == 1) begin
                fr = $urandom_range(0, 4);
                fw = $urandom_range(0, 4);
            end
            run_refill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 3),
                       $urandom_range(30, 100), fr, fw, dw, dd, dr, fd, wf);
            if (fd && wf < LINE) begin
                check("rnd_flush_done", dd, 0);
                check("rnd_flush_writes", dw, wf);
            end else begin
                check("rnd_writes", dw, 4);
                check("rnd_done", dd, 1);
                check("rnd_reqs", dr, 4);
            end
        end

        @(negedge clk);
        miss_v = 1'b0; flush = 1'b0; resp_v = 1'b0;
        @(negedge clk);
        #1 check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
